// File: rtl/midi_writer.sv
// Serial MIDI transmitter: latches a note-on/note-off request and shifts the
// three-byte message (status, note, velocity) out as 8N1 UART frames.
module midi_writer #(
  parameter int unsigned CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       midi_out,
  output logic       busy,
  output logic       done
);

  // Handshake: send acts as valid and !busy as ready. A request is taken on an
  // edge where the writer is idle (or finishing its last stop bit) and send=1;
  // send while busy is dropped, nothing is queued.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [11:0] TIMER_LAST = 12'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [11:0] timer;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  status_q;
  logic [7:0]  byte1_q;
  logic [7:0]  byte2_q;
  logic [7:0]  shreg;

  logic [7:0]  cur_byte;
  logic [7:0]  new_status;
  logic [7:0]  new_byte1;
  logic [7:0]  new_byte2;
  logic        bit_end;
  logic        last_byte;

  always_comb begin
    new_status = {(note_on ? 4'h9 : 4'h8), channel};
    new_byte1  = {1'b0, note};
    new_byte2  = {1'b0, velocity};
    bit_end    = (timer == TIMER_LAST);
    last_byte  = (byte_idx == 2'd2);
    case (byte_idx)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = byte1_q;
      default: cur_byte = byte2_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      status_q <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      shreg    <= '0;
      midi_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          midi_out <= 1'b1;
          busy     <= 1'b0;
          timer    <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (send) begin
            status_q <= new_status;
            byte1_q  <= new_byte1;
            byte2_q  <= new_byte2;
            busy     <= 1'b1;
            midi_out <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            timer    <= '0;
            bit_idx  <= '0;
            midi_out <= cur_byte[0];
            shreg    <= {1'b0, cur_byte[7:1]};
            state    <= DATA;
          end else begin
            timer <= timer + 12'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              midi_out <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              midi_out <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end else begin
            timer <= timer + 12'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
              midi_out <= 1'b0;
              state    <= START;
            end else begin
              done     <= 1'b1;
              byte_idx <= '0;
              // A request waiting at the end of the last stop bit starts the
              // next start bit immediately, so held-send streams have no gap.
              if (send) begin
                status_q <= new_status;
                byte1_q  <= new_byte1;
                byte2_q  <= new_byte2;
                midi_out <= 1'b0;
                state    <= START;
              end else begin
                busy     <= 1'b0;
                midi_out <= 1'b1;
                state    <= IDLE;
              end
            end
          end else begin
            timer <= timer + 12'd1;
          end
        end

        default: begin
          state    <= IDLE;
          midi_out <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_writer.sv
// Bench for midi_writer: one instance at 128 clocks/bit, one at 4 clocks/bit;
// the serial line is decoded at mid-bit and compared with hand-computed bytes.
module tb_midi_writer;

  logic       clk;
  logic       rst;
  logic       send_a;
  logic       send_b;
  logic       note_on;
  logic [3:0] channel;
  logic [7:0] note_w;
  logic [7:0] vel_w;
  logic       midi_a, busy_a, done_a;
  logic       midi_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  midi_writer #(.CLKS_PER_BIT(128)) dut_a (
    .clk(clk), .rst(rst), .send(send_a), .note_on(note_on), .channel(channel),
    .note(note_w[6:0]), .velocity(vel_w[6:0]),
    .midi_out(midi_a), .busy(busy_a), .done(done_a)
  );

  midi_writer #(.CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .rst(rst), .send(send_b), .note_on(note_on), .channel(channel),
    .note(note_w[6:0]), .velocity(vel_w[6:0]),
    .midi_out(midi_b), .busy(busy_b), .done(done_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard of expected messages ({status, byte1, byte2})
  logic [23:0] exp_q[$];

  typedef struct {
    bit         on;
    logic [3:0] ch;
    logic [7:0] nt;
    logic [7:0] vel;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];

  // driver: sets inputs, holds send for the acceptance edge, then scrambles inputs
  task automatic send_msg(input bit use_b, input bit on, input logic [3:0] ch,
                          input logic [7:0] nt, input logic [7:0] vel);
    note_on = on;
    channel = ch;
    note_w  = nt;
    vel_w   = vel;
    if (use_b) send_b = 1'b1; else send_a = 1'b1;
    tick();
    send_a  = 1'b0;
    send_b  = 1'b0;
    note_on = ~on;
    channel = ~ch;
    note_w  = ~nt;
    vel_w   = ~vel;
  endtask

  // Called 1 time unit after acceptance edge E0; returns 1 time unit after E0+30*cpb.
  task automatic run_frame(input bit use_b, input int cpb, input int inject_at,
                           output logic [23:0] msg, output bit frame_ok,
                           output bit busy_ok, output int dones);
    logic [29:0] bits;
    bits     = '0;
    frame_ok = 1'b1;
    busy_ok  = 1'b1;
    dones    = 0;
    for (int c = 0; c < 30 * cpb; c++) begin
      if ((use_b ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
      if ((use_b ? done_b : done_a) === 1'b1) dones++;
      if (c % cpb == cpb / 2) bits[c / cpb] = use_b ? midi_b : midi_a;
      if (c == inject_at) begin
        note_w = 8'h10;
        vel_w  = 8'h11;
        if (use_b) send_b = 1'b1; else send_a = 1'b1;
      end
      if (c == inject_at + 1) begin
        send_a = 1'b0;
        send_b = 1'b0;
      end
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      if (bits[10*j] !== 1'b0 || bits[10*j+9] !== 1'b1) frame_ok = 1'b0;
      msg[23-8*j -: 8] = bits[10*j+1 +: 8];
    end
  endtask

  task automatic check_frame(input string name, input bit use_b, input int cpb,
                             input int inject_at, input int exp_dones);
    logic [23:0] got, exp;
    bit fok, bok;
    int dn;
    run_frame(use_b, cpb, inject_at, got, fok, bok, dn);
    exp = exp_q.pop_front();
    check({name, "_bytes"}, {8'h0, got}, {8'h0, exp});
    check({name, "_framing"}, {31'h0, fok}, 32'd1);
    check({name, "_busy_hold"}, {31'h0, bok}, 32'd1);
    check({name, "_done_in_frame"}, dn, exp_dones);
  endtask

  task automatic check_end(input string name, input bit use_b);
    check({name, "_end_busy"}, {31'h0, use_b ? busy_b : busy_a}, 32'd0);
    check({name, "_end_done"}, {31'h0, use_b ? done_b : done_a}, 32'd1);
    check({name, "_end_line"}, {31'h0, use_b ? midi_b : midi_a}, 32'd1);
    tick();
    check({name, "_done_clear"}, {31'h0, use_b ? done_b : done_a}, 32'd0);
  endtask

  initial begin
    bit stable;
    int extra_done;

    vecs[0] = '{1'b1, 4'h0, 8'h3C, 8'h64, 24'h903C64};
    vecs[1] = '{1'b0, 4'hF, 8'h7F, 8'h00, 24'h8F7F00};
    vecs[2] = '{1'b0, 4'hF, 8'hFF, 8'h80, 24'h8F7F00};
    vecs[3] = '{1'b1, 4'h5, 8'hAA, 8'hD5, 24'h952A55};
    vecs[4] = '{1'b1, 4'hA, 8'h01, 8'hFF, 24'h9A017F};
    vecs[5] = '{1'b0, 4'h3, 8'h00, 8'h40, 24'h830040};

    send_a = 0; send_b = 0; note_on = 0; channel = 0; note_w = 0; vel_w = 0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_line_a", {31'h0, midi_a}, 32'd1);
    check("rst_busy_a", {31'h0, busy_a}, 32'd0);
    check("rst_done_a", {31'h0, done_a}, 32'd0);
    check("rst_line_b", {31'h0, midi_b}, 32'd1);
    rst = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (midi_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
          midi_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) stable = 1'b0;
    end
    check("idle_stable", {31'h0, stable}, 32'd1);

    // table-driven messages at 4 clocks/bit
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp);
      send_msg(1'b1, vecs[v].on, vecs[v].ch, vecs[v].nt, vecs[v].vel);
      check_frame($sformatf("vec%0d", v), 1'b1, 4, -10, 0);
      check_end($sformatf("vec%0d", v), 1'b1);
      tick();
    end

    // Note On at 128 clocks/bit, then again with a send injected mid-message
    exp_q.push_back(24'h903C64);
    send_msg(1'b0, 1'b1, 4'h0, 8'h3C, 8'h64);
    check_frame("on60", 1'b0, 128, -10, 0);
    check_end("on60", 1'b0);

    exp_q.push_back(24'h903C64);
    send_msg(1'b0, 1'b1, 4'h0, 8'h3C, 8'h64);
    check_frame("ignore_busy", 1'b0, 128, 999, 0);
    check_end("ignore_busy", 1'b0);
    extra_done = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy_a !== 1'b0 || done_a !== 1'b0) extra_done++;
      tick();
    end
    check("ignore_busy_no_second", extra_done, 0);

    // reset in the middle of byte 0 data bits
    send_msg(1'b0, 1'b1, 4'h0, 8'h3C, 8'h64);
    repeat (698) tick();
    check("midrst_busy_before", {31'h0, busy_a}, 32'd1);
    rst    = 1'b1;
    send_a = 1'b1;
    tick();
    check("midrst_line", {31'h0, midi_a}, 32'd1);
    check("midrst_busy", {31'h0, busy_a}, 32'd0);
    tick();
    check("midrst_send_blocked", {31'h0, busy_a}, 32'd0);
    rst    = 1'b0;
    send_a = 1'b0;
    tick();
    exp_q.push_back(24'h971533);
    send_msg(1'b0, 1'b1, 4'h7, 8'h15, 8'h33);
    check_frame("after_rst", 1'b0, 128, -10, 0);
    check_end("after_rst", 1'b0);

    // back-to-back with send held high at 4 clocks/bit
    exp_q.push_back(24'h91407F);
    exp_q.push_back(24'h824101);
    note_on = 1'b1; channel = 4'h1; note_w = 8'h40; vel_w = 8'h7F;
    send_b  = 1'b1;
    tick();
    note_on = 1'b0; channel = 4'h2; note_w = 8'h41; vel_w = 8'h01;
    fork
      begin
        repeat (150) @(posedge clk);
        #2 send_b = 1'b0;
      end
    join_none
    check_frame("b2b_first", 1'b1, 4, -10, 0);
    check("b2b_start_at_120", {31'h0, midi_b}, 32'd0);
    check("b2b_busy_at_120", {31'h0, busy_b}, 32'd1);
    check("b2b_done_at_120", {31'h0, done_b}, 32'd1);
    check_frame("b2b_second", 1'b1, 4, -10, 1);
    check_end("b2b_second", 1'b1);
    check("b2b_stays_idle", {31'h0, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
